// File: rtl/loba_mac_accum.sv
// Signed product accumulator: one dot-product result per p_last-terminated packet.
// Define LOBA_MAC_ACCUM_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module loba_mac_accum #(
  parameter int PW = 32,
  parameter int AW = 40,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [PW-1:0] p_data,
  input  logic          p_last,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [AW-1:0] r_data,
  output logic [CW-1:0] r_count,
  output logic          r_ovf
);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic signed [PW-1:0] p_s;
  logic [AW-1:0] p_ext;
  logic [AW-1:0] sum_raw;
  logic [AW-1:0] sum;
  logic          ovf_now;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          hold;

`ifdef LOBA_MAC_ACCUM_SAT_EN
  localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};
`endif

  assign p_s   = p_data;
  assign p_ext = AW'(p_s);

  assign hold    = r_valid && !r_ready;
  assign p_ready = !clr && !hold;
  assign accept  = p_valid && p_ready;

  always_comb begin
    sum_raw = acc + p_ext;
    ovf_now = (acc[AW-1] == p_ext[AW-1]) &&
              (sum_raw[AW-1] != acc[AW-1]);
`ifdef LOBA_MAC_ACCUM_SAT_EN
    sum = sum_raw;
    if (ovf_now) begin
      sum = acc[AW-1] ? MINV : MAXV;
    end
`else
    sum = sum_raw;
`endif
    cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (clr) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        if (p_last) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end else begin
          acc <= sum;
          cnt <= cnt_nxt;
          ovf <= ovf | ovf_now;
        end
      end
      // A last beat in the retiring cycle replaces the result without a bubble
      if (accept && p_last) begin
        r_valid <= 1'b1;
        r_data  <= sum;
        r_count <= cnt_nxt;
        r_ovf   <= ovf | ovf_now;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_loba_mac_accum.sv
// Directed bench for loba_mac_accum: default 32/40/16 instance plus
// an 8/8/4 instance for overflow and count saturation.
module tb_loba_mac_accum;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        p_valid;
  logic        p_ready;
  logic [31:0] p_data;
  logic        p_last;
  logic        r_valid;
  logic        r_ready;
  logic [39:0] r_data;
  logic [15:0] r_count;
  logic        r_ovf;

  logic        s_clr;
  logic        s_p_valid;
  logic        s_p_ready;
  logic [7:0]  s_p_data;
  logic        s_p_last;
  logic        s_r_valid;
  logic        s_r_ready;
  logic [7:0]  s_r_data;
  logic [3:0]  s_r_count;
  logic        s_r_ovf;

  int errors;
  int checks;

  loba_mac_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .p_valid(p_valid), .p_ready(p_ready),
    .p_data(p_data), .p_last(p_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_count(r_count),
    .r_ovf(r_ovf)
  );

  loba_mac_accum #(.PW(8), .AW(8), .CW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(s_clr),
    .p_valid(s_p_valid), .p_ready(s_p_ready),
    .p_data(s_p_data), .p_last(s_p_last),
    .r_valid(s_r_valid), .r_ready(s_r_ready),
    .r_data(s_r_data), .r_count(s_r_count),
    .r_ovf(s_r_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    checks++;
    if (r_valid !== 1'b0 || r_data !== 40'd0 ||
        r_count !== 16'd0 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%0d c=%0d o=%b want all 0",
               r_valid, r_data, r_count, r_ovf);
    end
    checks++;
    if (p_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", p_ready);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_packet();
    int vals[3];
    vals = '{3, -5, 100};
    r_ready = 1;
    p_valid = 1;
    for (int i = 0; i < 3; i++) begin
      p_data = 32'(vals[i]);
      p_last = (i == 2);
      #1;
      checks++;
      if (p_ready !== 1'b1) begin
        errors++;
        $display("FAIL pkt_ready beat %0d: got %b want 1", i, p_ready);
      end
      tick();
    end
    p_valid = 0;
    p_last = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== 40'd98 ||
        r_count !== 16'd3 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL pkt_result: got v=%b d=%0d c=%0d o=%b want 1/98/3/0",
               r_valid, $signed(r_data), r_count, r_ovf);
    end
    tick();
    checks++;
    if (r_valid !== 1'b0) begin
      errors++;
      $display("FAIL pkt_retire: got %b want 0", r_valid);
    end
  endtask

  task automatic test_backpressure();
    r_ready = 0;
    p_valid = 1;
    p_data = 32'(-7);
    p_last = 1;
    tick();
    p_data = 32'd2;
    #1;
    checks++;
    if (r_valid !== 1'b1 || r_data !== 40'(-7) || p_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got v=%b d=%0d rdy=%b want 1/-7/0",
               r_valid, $signed(r_data), p_ready);
    end
    tick();
    checks++;
    if (r_valid !== 1'b1 || r_data !== 40'(-7) || r_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_stable: got v=%b d=%0d c=%0d want 1/-7/1",
               r_valid, $signed(r_data), r_count);
    end
    r_ready = 1;
    #1;
    checks++;
    if (p_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: p_ready got %b want 1", p_ready);
    end
    tick();
    p_valid = 0;
    p_last = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== 40'd2 || r_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_next: got v=%b d=%0d c=%0d want 1/2/1",
               r_valid, $signed(r_data), r_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    r_ready = 1;
    p_valid = 1;
    p_last = 1;
    for (int i = 1; i <= 4; i++) begin
      p_data = 32'(i);
      tick();
      checks++;
      if (r_valid !== 1'b1 || r_data !== 40'(i) || p_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b %0d: got v=%b d=%0d rdy=%b want 1/%0d/1",
                 i, r_valid, $signed(r_data), p_ready, i);
      end
    end
    p_valid = 0;
    p_last = 0;
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_pos;
    logic [7:0] exp_neg;
`ifdef LOBA_MAC_ACCUM_SAT_EN
    exp_pos = 8'h7f;
    exp_neg = 8'h80;
`else
    exp_pos = 8'h80;
    exp_neg = 8'h7f;
`endif
    s_r_ready = 1;
    s_p_valid = 1;
    s_p_data = 8'd127;
    s_p_last = 0;
    tick();
    s_p_data = 8'd1;
    s_p_last = 1;
    tick();
    checks++;
    if (s_r_valid !== 1'b1 || s_r_data !== exp_pos ||
        s_r_ovf !== 1'b1 || s_r_count !== 4'd2) begin
      errors++;
      $display("FAIL ovf_pos: got v=%b d=%h o=%b c=%0d want 1/%h/1/2",
               s_r_valid, s_r_data, s_r_ovf, s_r_count, exp_pos);
    end
    s_p_data = 8'd5;
    tick();
    checks++;
    if (s_r_data !== 8'd5 || s_r_ovf !== 1'b0 || s_r_count !== 4'd1) begin
      errors++;
      $display("FAIL ovf_clear: got d=%h o=%b c=%0d want 05/0/1",
               s_r_data, s_r_ovf, s_r_count);
    end
    s_p_data = 8'h80;
    s_p_last = 0;
    tick();
    s_p_data = 8'hff;
    s_p_last = 1;
    tick();
    checks++;
    if (s_r_data !== exp_neg || s_r_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: got d=%h o=%b want %h/1",
               s_r_data, s_r_ovf, exp_neg);
    end
    s_p_valid = 0;
    s_p_last = 0;
    tick();
  endtask

  task automatic test_count_sat();
    s_r_ready = 1;
    s_p_valid = 1;
    s_p_data = 8'd0;
    for (int i = 0; i < 17; i++) begin
      s_p_last = (i == 16);
      tick();
    end
    s_p_valid = 0;
    s_p_last = 0;
    checks++;
    if (s_r_valid !== 1'b1 || s_r_count !== 4'd15 || s_r_data !== 8'd0) begin
      errors++;
      $display("FAIL cnt_sat: got v=%b c=%0d d=%h want 1/15/00",
               s_r_valid, s_r_count, s_r_data);
    end
    tick();
  endtask

  task automatic test_clr();
    r_ready = 1;
    p_valid = 1;
    p_last = 0;
    p_data = 32'd10;
    tick();
    p_data = 32'd20;
    tick();
    clr = 1;
    p_data = 32'd99;
    #1;
    checks++;
    if (p_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %b want 0", p_ready);
    end
    tick();
    clr = 0;
    p_data = 32'd4;
    p_last = 1;
    tick();
    p_valid = 0;
    p_last = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== 40'd4 || r_count !== 16'd1) begin
      errors++;
      $display("FAIL clr_result: got v=%b d=%0d c=%0d want 1/4/1",
               r_valid, $signed(r_data), r_count);
    end
    tick();
  endtask

  task automatic test_async_reset();
    r_ready = 0;
    p_valid = 1;
    p_data = 32'd9;
    p_last = 1;
    tick();
    p_valid = 0;
    p_last = 0;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r_data !== 40'd0 ||
        r_count !== 16'd0 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL arst_hold: got v=%b d=%0d c=%0d o=%b want all 0",
               r_valid, $signed(r_data), r_count, r_ovf);
    end
    tick();
    rst_n = 1;
    r_ready = 1;
    p_valid = 1;
    p_data = 32'd5;
    tick();
    p_data = 32'd6;
    tick();
    p_valid = 0;
    #2;
    rst_n = 0;
    #1;
    rst_n = 1;
    tick();
    p_valid = 1;
    p_data = 32'hffff_ffff;
    p_last = 1;
    tick();
    p_valid = 0;
    p_last = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== 40'(-1) || r_count !== 16'd1) begin
      errors++;
      $display("FAIL arst_after: got v=%b d=%0d c=%0d want 1/-1/1",
               r_valid, $signed(r_data), r_count);
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 0;
    rst_n = 0;
    clr = 0;
    p_valid = 0;
    p_data = '0;
    p_last = 0;
    r_ready = 0;
    s_clr = 0;
    s_p_valid = 0;
    s_p_data = '0;
    s_p_last = 0;
    s_r_ready = 0;
    test_reset();
    test_packet();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_count_sat();
    test_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loba_mac_accum.md
Name: loba_mac_accum

Overview:
- Downstream consumer of the signed approximate multipliers (LOBA0s..LOBA3s, default 16x16 giving a 32-bit product).
- Accumulates a stream of signed products into a wide accumulator and emits one dot-product result per packet, where the last beat of a packet is marked by p_last.
- Valid/ready on both sides, single-entry output buffer, sticky overflow flag.
- Used to build approximate MAC/FIR datapaths for error characterisation.

Parameters:
PW, 32, product width (multiplier n+m), two's complement
AW, 40, accumulator and result width, two's complement, AW >= PW
CW, 16, beat-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of the in-progress packet
p_valid  in  1  product beat valid
p_ready  out  1  block can accept a beat
p_data  in  PW  signed product
p_last  in  1  beat is the last of its packet
r_valid  out  1  result valid
r_ready  in  1  downstream accepts the result
r_data  out  AW  signed accumulated sum
r_count  out  CW  number of beats in the packet
r_ovf  out  1  overflow occurred within the packet

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, cnt=0, ovf=0, r_valid=0, r_data=0, r_count=0, r_ovf=0. All outputs stay 0 until the first result.
- Handshake rules:
  - p_ready = !clr && !(r_valid && !r_ready). p_ready is combinational from r_valid, r_ready and clr; there is no combinational path from p_valid.
  - A beat is accepted when p_valid && p_ready.
  - r_valid, r_data, r_count and r_ovf hold stable while r_valid && !r_ready.
- Arithmetic:
  - sum = acc + sign-extend(p_data) to AW bits.
  - Signed overflow means both operands share a sign and sum differs from it. Overflow sets ovf (sticky for the packet).
  - Without the optional feature, sum wraps modulo 2^AW.
  - The next cnt value is cnt+1, saturating at 2^CW-1.
- Beat accepted with p_last=0: acc<=sum, cnt<=cnt+1 (sat), ovf<=ovf|overflow.
- Beat accepted with p_last=1 (result appears the next cycle):
  - r_data<=sum, r_count<=cnt+1 (sat), r_ovf<=ovf|overflow, r_valid<=1.
  - acc<=0, cnt<=0, ovf<=0.
  - A single-beat packet gives r_count=1 and r_data=sext(p_data).
- Result retirement: if r_valid && r_ready and no last beat is accepted in the same cycle, r_valid<=0.
- Back-to-back: a last beat accepted in the same cycle that r_ready retires the old result loads the new result, and r_valid stays 1. Full throughput is one beat per cycle.
- States (derived, not separately encoded):
  - IDLE: cnt=0 and r_valid=0.
  - ACCUM: cnt>0.
  - HOLD: r_valid && !r_ready, so p_ready=0.
  - ACCUM and HOLD can coexist. HOLD exits on r_ready.
- clr=1 (synchronous, highest priority):
  - acc, cnt and ovf go to 0, and no beat is accepted in that cycle (p_ready=0).
  - The output buffer (r_valid, r_data, r_count, r_ovf) is unaffected and still retires normally on r_ready.
- rst_n asserted mid-packet or mid-HOLD: everything clears immediately and the pending result is lost.
- p_data is don't-care when p_valid=0.

Optional Feature:
- Macro LOBA_MAC_ACCUM_SAT_EN.
- Defined: on overflow, sum is clamped to +(2^(AW-1)-1) or -2^(AW-1) according to the operands' sign, and the clamped value is stored in acc/r_data. Later beats accumulate from the clamped value. r_ovf is still reported.
- Undefined: sum wraps modulo 2^AW, and r_ovf is the only indication.
- r_count saturation is present in both builds.

Test Plan:
- Reset then packet: p_data = 3, -5, 100 (last on 100), r_ready=1 -> one cycle after the last beat: r_valid=1, r_data=98, r_count=3, r_ovf=0. p_ready stays 1 throughout.
- Backpressure: hold r_ready=0 after a 1-beat packet with p_data=-7 -> r_data=-7 held and p_ready=0. Present p_data=2 with last -> not accepted. Raise r_ready -> the -7 result retires and the 2 beat is accepted the same cycle. The next result is r_data=2, r_count=1, and r_valid never drops.
- Single-beat packets every cycle with r_ready=1 and p_data=1,2,3,4 -> r_data=1,2,3,4 on consecutive cycles, with no bubbles.
- Overflow with AW=PW=8 and packet 127, 1 (last):
  - Without the macro: r_data=-128, r_ovf=1.
  - With LOBA_MAC_ACCUM_SAT_EN: r_data=127, r_ovf=1.
  - A following packet of 5 (last) gives r_ovf=0.
- clr mid-packet: accept 10, 20, pulse clr while p_valid=1 with p_data=99 (not accepted since p_ready=0), then accept 4 with last -> r_data=4, r_count=1.
- Async reset while r_valid=1 and cnt=2 -> r_valid and all r_* go to 0 without waiting for a clk edge. A subsequent 1-beat packet of -1 gives r_data=-1, r_count=1.
